svm_decision_accum: RTL

- Downstream neighbour of the stage-1 kernel array.
- Consumes NUM_OF_SV kernel values per test sample, one per beat, each paired with its signed coefficient (alpha_i*y_i) from coefficient BRAM.
- Accumulates the weighted sum, adds bias b, and emits the class bit.
- Also emits an escalate flag that tells the cascade to forward the sample to stage 2 when the score margin is too small.

---
 rtl/svm_pkg.sv | 32 +++
 rtl/svm_decision_accum_if.sv | 33 +++
 rtl/svm_mac_unit.sv | 79 +++++++
 rtl/svm_decision_accum.sv | 134 +++++++++++++
 4 files changed

// File: rtl/svm_pkg.sv
// Shared types and width helpers for the SVM decision accumulator.
// DECISION_MUL_PIPE_EN (optional) adds a register after the multiplier and
// the DRAIN state that lets the last registered product land in the accumulator.
package svm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ACCUM  = 3'd1,
    ST_BIAS   = 3'd2,
    ST_DECIDE = 3'd3,
    ST_OUT    = 3'd4,
    ST_DRAIN  = 3'd5
  } state_e;

  // Kernel value carries four pixel-wide partial terms.
  function automatic int kern_w(input int xlen_pixel);
    return 4 * xlen_pixel;
  endfunction

  // Signed product of a zero-extended kernel and a signed coefficient.
  function automatic int prod_w(input int xlen_pixel, input int coef_w);
    return kern_w(xlen_pixel) + coef_w + 1;
  endfunction

  // Wide enough for NUM_OF_SV products plus bias without overflow.
  function automatic int acc_w(input int xlen_pixel, input int num_of_sv, input int coef_w);
    return kern_w(xlen_pixel) + coef_w + $clog2(num_of_sv) + 2;
  endfunction

  localparam int DEF_PROD_W = prod_w(8, 16);

endpackage

// File: rtl/svm_decision_accum_if.sv
// Beat input and result output handshakes of the decision accumulator.
interface svm_decision_accum_if
  import svm_pkg::*;
#(
  parameter int XLEN_PIXEL = 8,
  parameter int NUM_OF_SV  = 10,
  parameter int COEF_W     = 16
);
  localparam int KERN_W = kern_w(XLEN_PIXEL);
  localparam int ACC_W  = acc_w(XLEN_PIXEL, NUM_OF_SV, COEF_W);

  logic                     in_valid;
  logic                     in_ready;
  logic [KERN_W-1:0]        kernel_in;
  logic signed [COEF_W-1:0] coef_in;
  logic                     out_valid;
  logic                     out_ready;
  logic                     y_class;
  logic                     escalate;
  logic signed [ACC_W-1:0]  score;

  // Producer/consumer side (kernel array upstream, cascade downstream).
  modport master (
    output in_valid, kernel_in, coef_in, out_ready,
    input  in_ready, out_valid, y_class, escalate, score
  );

  // Accumulator side.
  modport slave (
    input  in_valid, kernel_in, coef_in, out_ready,
    output in_ready, out_valid, y_class, escalate, score
  );
endinterface

// File: rtl/svm_mac_unit.sv
// Multiply-accumulate datapath: zero-extended kernel times signed coefficient,
// summed into a wide signed accumulator, with clear and bias-add controls.
// With DECISION_MUL_PIPE_EN the product is registered (own valid bit) first.
module svm_mac_unit
  import svm_pkg::*;
#(
  parameter int KERN_W = 32,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 54
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     beat,
  input  logic [KERN_W-1:0]        kernel,
  input  logic signed [COEF_W-1:0] coef,
  input  logic                     bias_add,
  input  logic signed [COEF_W-1:0] bias,
  input  logic                     clr,
  output logic signed [ACC_W-1:0]  acc
);
  localparam int PROD_W = KERN_W + COEF_W + 1;

  logic signed [KERN_W:0]      kern_s;
  logic signed [PROD_W-1:0]    prod;
  logic signed [PROD_W-1:0]    add_prod;
  logic                        add_vld;
  logic signed [ACC_W-1:0]     acc_d, acc_q;

  assign kern_s = $signed({1'b0, kernel});
  assign prod   = kern_s * coef;

`ifdef DECISION_MUL_PIPE_EN
  logic signed [PROD_W-1:0] prod_d, prod_q;
  logic                     mul_vld_d, mul_vld_q;

  // Capture the product of each accepted beat; valid follows one cycle behind.
  always_comb begin
    prod_d    = prod_q;
    mul_vld_d = beat;
    if (beat) prod_d = prod;
  end

  // Product pipe register.
  always_ff @(posedge clk) begin
    if (rst) begin
      prod_q    <= '0;
      mul_vld_q <= 1'b0;
    end else begin
      prod_q    <= prod_d;
      mul_vld_q <= mul_vld_d;
    end
  end

  assign add_prod = prod_q;
  assign add_vld  = mul_vld_q;
`else
  assign add_prod = prod;
  assign add_vld  = beat;
`endif

  // Accumulator next value: clear wins, then bias, then product.
  always_comb begin
    acc_d = acc_q;
    if (clr)
      acc_d = '0;
    else if (bias_add)
      acc_d = acc_q + {{(ACC_W-COEF_W){bias[COEF_W-1]}}, bias};
    else if (add_vld)
      acc_d = acc_q + {{(ACC_W-PROD_W){add_prod[PROD_W-1]}}, add_prod};
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule

// File: rtl/svm_decision_accum.sv
// SVM decision stage: accumulates NUM_OF_SV weighted kernel beats, adds bias,
// then registers score, class bit and stage-2 escalate flag.
// Optional macro DECISION_MUL_PIPE_EN pipelines the multiplier (+1 latency).
module svm_decision_accum
  import svm_pkg::*;
#(
  parameter int XLEN_PIXEL = 8,
  parameter int NUM_OF_SV  = 10,
  parameter int COEF_W     = 16,
  localparam int KERN_W    = kern_w(XLEN_PIXEL),
  localparam int ACC_W     = acc_w(XLEN_PIXEL, NUM_OF_SV, COEF_W)
) (
  input  logic                     clk,
  input  logic                     rst,
  svm_decision_accum_if.slave      bus,
  input  logic signed [COEF_W-1:0] bias,
  input  logic [ACC_W-2:0]         margin_thresh
);
  localparam int CNT_W = $clog2(NUM_OF_SV + 1);

`ifdef DECISION_MUL_PIPE_EN
  localparam state_e ST_AFTER_LAST = ST_DRAIN;
`else
  localparam state_e ST_AFTER_LAST = ST_BIAS;
`endif

  state_e                  state_d, state_q;
  logic [CNT_W-1:0]        beat_cnt_d, beat_cnt_q;
  logic                    out_valid_d, out_valid_q;
  logic                    y_class_d, y_class_q;
  logic                    escalate_d, escalate_q;
  logic signed [ACC_W-1:0] score_d, score_q;

  logic                    in_ready;
  logic                    beat;
  logic                    mac_bias;
  logic                    mac_clr;
  logic signed [ACC_W-1:0] acc;
  logic [ACC_W-1:0]        acc_mag;

  assign in_ready = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
  assign beat     = bus.in_valid & in_ready;
  // Most-negative value is unreachable at this width, so negation is exact.
  assign acc_mag  = acc[ACC_W-1] ? (~acc + ACC_W'(1)) : acc;

  svm_mac_unit #(
    .KERN_W (KERN_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .beat     (beat),
    .kernel   (bus.kernel_in),
    .coef     (bus.coef_in),
    .bias_add (mac_bias),
    .bias     (bias),
    .clr      (mac_clr),
    .acc      (acc)
  );

  // Sample sequencing and result capture.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    out_valid_d = out_valid_q;
    y_class_d   = y_class_q;
    escalate_d  = escalate_q;
    score_d     = score_q;
    mac_bias    = 1'b0;
    mac_clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (beat) begin
          beat_cnt_d = CNT_W'(1);
          state_d    = (NUM_OF_SV == 1) ? ST_AFTER_LAST : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (beat) begin
          beat_cnt_d = beat_cnt_q + CNT_W'(1);
          if (beat_cnt_q == CNT_W'(NUM_OF_SV - 1)) state_d = ST_AFTER_LAST;
        end
      end
      // Last registered product lands in the accumulator here.
      ST_DRAIN: state_d = ST_BIAS;
      ST_BIAS: begin
        mac_bias = 1'b1;
        state_d  = ST_DECIDE;
      end
      ST_DECIDE: begin
        score_d     = acc;
        y_class_d   = ~acc[ACC_W-1];
        escalate_d  = acc_mag < {1'b0, margin_thresh};
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          mac_clr     = 1'b1;
          beat_cnt_d  = '0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      beat_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      y_class_q   <= 1'b0;
      escalate_q  <= 1'b0;
      score_q     <= '0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      out_valid_q <= out_valid_d;
      y_class_q   <= y_class_d;
      escalate_q  <= escalate_d;
      score_q     <= score_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.y_class   = y_class_q;
  assign bus.escalate  = escalate_q;
  assign bus.score     = score_q;
endmodule
